bidir_rx_fifo: RTL and testbench
================================

BIDIR_RX_FIFO -- requirements
Module: bidir_rx_fifo

Interface
REQ-001 SHALL have parameter DW, default 32, meaning stream tdata width in bits.
REQ-002 SHALL have parameter UW, default 4, meaning tuser width.
REQ-003 SHALL have parameter SW, default 4, meaning tstrb width.
REQ-004 SHALL have parameter DEPTH, default 16, meaning entry count; a power of 2, at least 2.
REQ-005 SHALL have parameter AFULL_THR, default 12, meaning almost-full level, 1..DEPTH.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-008 SHALL have port flush, input, 1 bit, synchronous clear of the buffer contents.
REQ-009 SHALL have ports s_tvalid, s_tdata, s_tuser, s_tstrb, s_tlast as inputs of widths 1/DW/UW/SW/1, meaning the upstream stream from the bidir RX path.
REQ-010 SHALL have port s_tready, output, 1 bit, meaning the FIFO can accept a beat.
REQ-011 SHALL have ports m_tvalid, m_tdata, m_tuser, m_tstrb, m_tlast as outputs of widths 1/DW/UW/SW/1, meaning the downstream stream.
REQ-012 SHALL have port m_tready, input, 1 bit, meaning the downstream accepts a beat.
REQ-013 SHALL have port level, output, $clog2(DEPTH+1) bits, meaning stored beat count.
REQ-014 SHALL have port pkt_cnt, output, $clog2(DEPTH+1) bits, meaning count of stored beats with tlast=1.
REQ-015 SHALL have ports empty, full and afull, outputs, 1 bit each, meaning level==0, level==DEPTH and level>=AFULL_THR.

Function
REQ-016 SHALL define push as s_tvalid && s_tready and pop as m_tvalid && m_tready, both sampled at the rising edge.
REQ-017 SHALL drive s_tready = !full && !flush, registered-state only, with no combinational path from m_tready.
REQ-018 SHALL be first-word-fall-through: m_tvalid = !empty, and m_tdata/m_tuser/m_tstrb/m_tlast present the head entry directly.
REQ-019 SHALL give 1 cycle of latency: a push into an empty FIFO at edge N makes m_tvalid=1 in the cycle after edge N.
REQ-020 SHALL store {tdata, tuser, tstrb, tlast} per entry, with write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-021 SHALL update level on the same edge as push/pop: +1 on push only, -1 on pop only, unchanged on push and pop together.
REQ-022 SHALL allow simultaneous push and pop at any non-full, non-empty level, with level unchanged.
REQ-023 SHALL treat the full case as follows: s_tready=0, so no push occurs; a pop that edge leaves level=DEPTH-1, and s_tready returns to 1 the next cycle.
REQ-024 SHALL treat the empty case as follows: m_tvalid=0 and no pop occurs; the head outputs are don't-care but stable.
REQ-025 SHALL update pkt_cnt as follows: +1 on a push with s_tlast=1, -1 on a pop with m_tlast=1, net on both; it never exceeds level.
REQ-026 SHALL update afull, full and empty combinationally from the registered level.
REQ-027 SHALL, on flush=1 at an edge, zero both pointers, level and pkt_cnt; any push or pop that edge is discarded; s_tready=0 while flush is high.
REQ-028 SHALL NOT alter an entry's contents once written until it is popped; tdata beats SHALL leave in write order, bit-exact.

Reset
REQ-029 SHALL, with rst=1 at an edge, set pointers=0, level=0 and pkt_cnt=0; the resulting outputs are m_tvalid=0, empty=1, full=0, afull=0, and s_tready=1 once rst=0.
REQ-030 SHALL hold s_tready=0 while rst=1.
REQ-031 SHALL NOT reset the storage array; its contents are unobservable because empty=1.
REQ-032 SHALL let rst take priority over flush and over any push or pop.
REQ-033 SHALL, if rst asserts mid-packet, discard the partial packet, with no beat of it appearing on the m_ port afterward.

Verification
REQ-034 SHALL cover this scenario: push 1 beat (tdata=0xA5A5_0001, tlast=1) into the empty FIFO -> next cycle m_tvalid=1, m_tdata=0xA5A5_0001, level=1, pkt_cnt=1.
REQ-035 SHALL cover this scenario: push 16 beats with m_tready=0 -> afull=1 after the 12th push, full=1 and s_tready=0 after the 16th; a 17th offered beat is not accepted.
REQ-036 SHALL cover this scenario: at full, one cycle with m_tready=1 -> level=15 and s_tready=1 next cycle; the popped beat is the first written.
REQ-037 SHALL cover this scenario: continuous push and pop at level=5 for 40 cycles -> level stays 5, output order matches input order, and pointers wrap with no data corruption.
REQ-038 SHALL cover this scenario: 3 packets of lengths 2/3/4 stored, then flush=1 for 1 cycle -> level=0, pkt_cnt=0, m_tvalid=0 next cycle.
REQ-039 SHALL cover this scenario: rst=1 after 2 beats of a 4-beat packet -> empty=1 and pkt_cnt=0; after rst drops, a new packet passes through alone with no stale beats.

Source files
------------

// File: rtl/bidir_rx_fifo.sv
// bidir_rx_fifo: first-word-fall-through stream FIFO for the bidir RX path,
// tracking stored beat count and stored packet-end count.
module bidir_rx_fifo #(
   parameter int DW        = 32,
   parameter int UW        = 4,
   parameter int SW        = 4,
   parameter int DEPTH     = 16,
   parameter int AFULL_THR = 12
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         s_tvalid,
   input  logic [DW-1:0]                s_tdata,
   input  logic [UW-1:0]                s_tuser,
   input  logic [SW-1:0]                s_tstrb,
   input  logic                         s_tlast,
   output logic                         s_tready,
   output logic                         m_tvalid,
   output logic [DW-1:0]                m_tdata,
   output logic [UW-1:0]                m_tuser,
   output logic [SW-1:0]                m_tstrb,
   output logic                         m_tlast,
   input  logic                         m_tready,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic [$clog2(DEPTH+1)-1:0]   pkt_cnt,
   output logic                         empty,
   output logic                         full,
   output logic                         afull
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam int EW = DW + UW + SW + 1;

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push, pop;

   assign empty    = level == '0;
   assign full     = level == LW'(DEPTH);
   assign afull    = level >= LW'(AFULL_THR);
   // ready depends only on registered state and the rst/flush controls
   assign s_tready = !full && !flush && !rst;
   assign m_tvalid = !empty;
   assign push     = s_tvalid && s_tready;
   assign pop      = m_tvalid && m_tready;
   assign {m_tlast, m_tuser, m_tstrb, m_tdata} = mem[rd_ptr];

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {s_tlast, s_tuser, s_tstrb, s_tdata};

   always_ff @(posedge clk)
      if (rst || flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         pkt_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         level   <= level + LW'(push) - LW'(pop);
         pkt_cnt <= pkt_cnt + LW'(push && s_tlast) - LW'(pop && m_tlast);
      end
endmodule

// File: tb/tb_bidir_rx_fifo.sv
// tb_bidir_rx_fifo: directed self-checking bench for bidir_rx_fifo.
module tb_bidir_rx_fifo;
   localparam int DW = 32, UW = 4, SW = 4, DEPTH = 16, AFULL_THR = 12;
   localparam int LW = $clog2(DEPTH+1);
   localparam int EW = DW + UW + SW + 1;

   logic          clk = 0, rst = 1, flush = 0;
   logic          s_tvalid = 0, s_tlast = 0, s_tready;
   logic [DW-1:0] s_tdata = '0;
   logic [UW-1:0] s_tuser = '0;
   logic [SW-1:0] s_tstrb = '0;
   logic          m_tvalid, m_tlast, m_tready = 0;
   logic [DW-1:0] m_tdata;
   logic [UW-1:0] m_tuser;
   logic [SW-1:0] m_tstrb;
   logic [LW-1:0] level, pkt_cnt;
   logic          empty, full, afull;
   logic [EW-1:0] q [$];
   int            checks = 0, errors = 0;

   always #5 clk = ~clk;

   bidir_rx_fifo #(.DW(DW), .UW(UW), .SW(SW), .DEPTH(DEPTH), .AFULL_THR(AFULL_THR)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tstrb(s_tstrb),
      .s_tlast(s_tlast), .s_tready(s_tready),
      .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tstrb(m_tstrb),
      .m_tlast(m_tlast), .m_tready(m_tready),
      .level(level), .pkt_cnt(pkt_cnt), .empty(empty), .full(full), .afull(afull)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [EW-1:0] ent(input logic [DW-1:0] d, input logic l);
      return {l, d[7:4], d[3:0], d};
   endfunction

   // one clock with the given inputs; the queue model decides what is accepted
   task automatic xfer(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
      logic do_push, do_pop;
      s_tvalid = v; s_tdata = d; s_tuser = d[7:4]; s_tstrb = d[3:0]; s_tlast = l; m_tready = r;
      #1;
      do_push = v && q.size() < DEPTH;
      do_pop  = r && q.size() > 0;
      chk("m_tvalid", m_tvalid, q.size() > 0);
      if (do_pop) chk("head", {m_tlast, m_tuser, m_tstrb, m_tdata}, q[0]);
      @(posedge clk);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(ent(d, l));
      #1;
      s_tvalid = 0; m_tready = 0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_empty", empty, 1);
      chk("rst_mvalid", m_tvalid, 0);
      chk("rst_full", full, 0);
      chk("rst_afull", afull, 0);
      chk("rst_level", level, 0);
      chk("rst_pkt", pkt_cnt, 0);
      chk("rst_sready", s_tready, 0);
      rst = 0;
      #1;
      chk("sready_after_rst", s_tready, 1);

      xfer(1, 32'hA5A5_0001, 1, 0);
      chk("one_mvalid", m_tvalid, 1);
      chk("one_data", m_tdata, 32'hA5A5_0001);
      chk("one_level", level, 1);
      chk("one_pkt", pkt_cnt, 1);
      xfer(0, 0, 0, 1);
      chk("one_empty", empty, 1);
      chk("one_pkt0", pkt_cnt, 0);

      for (int i = 0; i < 16; i++) begin
         xfer(1, 32'h100 + i, i % 4 == 3, 0);
         chk("fill_level", level, i + 1);
         chk("fill_afull", afull, i >= 11);
         chk("fill_full", full, i == 15);
      end
      chk("full_sready", s_tready, 0);
      chk("full_pkt", pkt_cnt, 4);
      xfer(1, 32'h1FF, 1, 0);
      chk("no17_level", level, 16);
      chk("no17_pkt", pkt_cnt, 4);

      xfer(0, 0, 0, 1);
      chk("pop_full_level", level, 15);
      chk("pop_full_sready", s_tready, 1);
      chk("pop_full_pkt", pkt_cnt, 4);
      for (int i = 0; i < 15; i++) xfer(0, 0, 0, 1);
      chk("drain_empty", empty, 1);
      chk("drain_pkt", pkt_cnt, 0);

      for (int i = 0; i < 5; i++) xfer(1, 32'h200 + i, 0, 0);
      for (int k = 0; k < 40; k++) begin
         xfer(1, 32'h300 + k, k % 3 == 0, 1);
         chk("stream_level", level, 5);
      end
      for (int i = 0; i < 5; i++) xfer(0, 0, 0, 1);
      chk("stream_empty", empty, 1);

      for (int i = 0; i < 9; i++) xfer(1, 32'h400 + i, i == 1 || i == 4 || i == 8, 0);
      chk("pk_level", level, 9);
      chk("pk_cnt", pkt_cnt, 3);
      flush = 1; s_tvalid = 1; m_tready = 1; s_tdata = 32'h4FF;
      #1;
      chk("flush_sready", s_tready, 0);
      @(posedge clk);
      #1;
      flush = 0; s_tvalid = 0; m_tready = 0;
      q.delete();
      chk("flush_level", level, 0);
      chk("flush_pkt", pkt_cnt, 0);
      chk("flush_mvalid", m_tvalid, 0);

      xfer(1, 32'h500, 0, 0);
      xfer(1, 32'h501, 0, 0);
      rst = 1;
      #1;
      chk("rst_mid_sready", s_tready, 0);
      @(posedge clk);
      #1;
      rst = 0;
      q.delete();
      chk("rst_mid_empty", empty, 1);
      chk("rst_mid_pkt", pkt_cnt, 0);
      xfer(1, 32'h600, 0, 0);
      xfer(1, 32'h601, 1, 0);
      chk("new_pkt_level", level, 2);
      chk("new_pkt_cnt", pkt_cnt, 1);
      xfer(0, 0, 0, 1);
      xfer(0, 0, 0, 1);
      chk("new_pkt_empty", empty, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
